// File: rtl/hazard_control_unit.sv
// Stall/flush/hold generator for the RV32I 5-stage pipeline with a data-memory wait FSM.
// Optional performance counters are built only when HCU_PERF_CNT_EN is defined.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             PCSrc,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Stall,
    output logic             IF_ID_Flush,
    output logic             Control_Sig_Stall,
    output logic             ID_EX_Flush,
    output logic             ID_EX_Hold,
    output logic             EX_MEM_Hold,
    output logic             MEM_WB_Hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_next;
    logic       r_mem_timeout;
    logic       w_mem_timeout_next;
    logic       w_load_use;
    logic       w_mem_busy;

    // Hazard detection; x0 never carries a dependency.
    always_comb begin
        w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                     ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
        w_mem_busy = (r_state == ST_MEM_WAIT) ||
                     ((r_state == ST_RUN) && dmem_req && !dmem_ready);
    end

    // Memory-wait FSM next state, saturating wait counter and sticky timeout.
    always_comb begin
        w_state_next       = r_state;
        w_wait_cnt_next    = r_wait_cnt;
        w_mem_timeout_next = r_mem_timeout;
        case (r_state)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    w_state_next    = ST_MEM_WAIT;
                    w_wait_cnt_next = 8'd1;
                end else begin
                    w_state_next    = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // A dropped dmem_req is a protocol error; only dmem_ready ends the wait.
                if (dmem_ready) begin
                    w_state_next    = ST_RUN;
                    w_wait_cnt_next = 8'd0;
                end else begin
                    if (r_wait_cnt != 8'd255) begin
                        w_wait_cnt_next = r_wait_cnt + 8'd1;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt;
                    end
                    if (w_wait_cnt_next == LP_TIMEOUT) begin
                        w_mem_timeout_next = 1'b1;
                    end else begin
                        w_mem_timeout_next = r_mem_timeout;
                    end
                end
            end
            default: begin
                w_state_next    = ST_RUN;
                w_wait_cnt_next = 8'd0;
            end
        endcase
    end

    // FSM state, wait counter and timeout flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_mem_timeout <= w_mem_timeout_next;
        end
    end

    // Prioritised pipeline controls; reset forces both flushes so no stale instruction issues.
    always_comb begin
        PC_Write          = 1'b1;
        IF_ID_Stall       = 1'b0;
        IF_ID_Flush       = 1'b0;
        Control_Sig_Stall = 1'b0;
        ID_EX_Flush       = 1'b0;
        ID_EX_Hold        = 1'b0;
        EX_MEM_Hold       = 1'b0;
        MEM_WB_Hold       = 1'b0;
        mem_timeout       = r_mem_timeout;
        if (!rst_n) begin
            PC_Write    = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            mem_timeout = 1'b0;
        end else if (w_mem_busy) begin
            PC_Write    = 1'b0;
            IF_ID_Stall = 1'b1;
            ID_EX_Hold  = 1'b1;
            EX_MEM_Hold = 1'b1;
            MEM_WB_Hold = 1'b1;
        end else if (PCSrc) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (w_load_use) begin
            PC_Write          = 1'b0;
            IF_ID_Stall       = 1'b1;
            Control_Sig_Stall = 1'b1;
        end else begin
            PC_Write = 1'b1;
        end
    end

`ifdef HCU_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall_cnt;
    logic [CNT_W-1:0] r_perf_flush_cnt;
    logic             w_prio_flush;
    logic             w_prio_stall;

    assign w_prio_flush = !w_mem_busy && PCSrc;
    assign w_prio_stall = !w_mem_busy && !PCSrc && w_load_use;

    // Wrapping event counters for redirect flushes and load-use stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_prio_stall) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + CNT_W'(1);
            end
            if (w_prio_flush) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Central stall/flush generator for the RV32I 5-stage pipeline. It drives the stall, flush and hold inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. It resolves three hazards in a fixed priority order:
- data-memory wait,
- control redirect from EX,
- load-use.

A small FSM tracks multi-cycle data-memory waits and raises a sticky timeout flag.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before mem_timeout sets (range 2..255)
CNT_W, 32, width of performance counters (only with HCU_PERF_CNT_EN)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
IF_ID_Rs1  input  5  rs1 field of the instruction in ID
IF_ID_Rs2  input  5  rs2 field of the instruction in ID
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_Rd  input  5  destination register of the instruction in EX
PCSrc  input  1  branch taken or jump resolved in EX (redirect)
dmem_req  input  1  EX/MEM stage holds a load or store this cycle
dmem_ready  input  1  data memory completes the access this cycle
PC_Write  output  1  PC update enable
IF_ID_Stall  output  1  hold IF/ID
IF_ID_Flush  output  1  load NOP (32'h00000013) into IF/ID
Control_Sig_Stall  output  1  insert bubble into ID/EX (zero controls)
ID_EX_Flush  output  1  clear ID/EX
ID_EX_Hold  output  1  freeze ID/EX contents unchanged
EX_MEM_Hold  output  1  freeze EX/MEM
MEM_WB_Hold  output  1  freeze MEM/WB
mem_timeout  output  1  sticky: a memory wait exceeded MEM_TIMEOUT
perf_stall_cnt  output  CNT_W  load-use stall cycles (HCU_PERF_CNT_EN only)
perf_flush_cnt  output  CNT_W  redirect flushes (HCU_PERF_CNT_EN only)

Behaviour:
Reset and registered state
- While rst_n=0, outputs are forced regardless of other inputs:
  - PC_Write=0, IF_ID_Flush=1, ID_EX_Flush=1.
  - All stalls and holds = 0.
  - mem_timeout=0, counters=0.
  - FSM = RUN, wait counter = 0.
- Registered state is limited to: FSM state, wait counter (8 bit), mem_timeout and perf counters. All other outputs are combinational from state and inputs, so there is zero-cycle latency.

Hazard conditions
- load_use = ID_EX_MemRead && ID_EX_Rd!=0 && (ID_EX_Rd==IF_ID_Rs1 || ID_EX_Rd==IF_ID_Rs2).
- mem_busy = (state==MEM_WAIT) || (state==RUN && dmem_req && !dmem_ready).

Output priority (evaluated per cycle)
1. mem_busy:
   - PC_Write=0, IF_ID_Stall=1.
   - ID_EX_Hold=1, EX_MEM_Hold=1, MEM_WB_Hold=1.
   - Both flushes 0 and Control_Sig_Stall=0.
   - PCSrc and load_use are ignored. EX is frozen, so both are re-evaluated after the wait ends.
2. PCSrc:
   - PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
   - Stalls and holds = 0. load_use is ignored because the ID instruction is discarded.
3. load_use:
   - PC_Write=0, IF_ID_Stall=1, Control_Sig_Stall=1.
   - Flushes and holds = 0.
   - The condition clears on the next cycle once the bubble reaches EX, so exactly 1 stall cycle.
4. Otherwise: PC_Write=1, all other control outputs 0.

FSM
- RUN → MEM_WAIT when dmem_req && !dmem_ready; wait counter loads 1.
- MEM_WAIT → RUN on dmem_ready. Holds are still asserted in that completing cycle; the pipeline advances on the following edge.
- In MEM_WAIT with !dmem_ready: wait counter increments, saturating at 255.
  - When the counter reaches MEM_TIMEOUT, mem_timeout sets.
  - mem_timeout stays set until reset. The FSM keeps waiting; there is no forced abort.
- dmem_req deasserting during MEM_WAIT is a protocol error. The FSM stays in MEM_WAIT until dmem_ready.
- dmem_req && dmem_ready in RUN: zero-wait access, no stall, FSM stays in RUN.
- Async reset mid-wait: FSM returns to RUN immediately and the wait counter is cleared.

Optional Feature:
HCU_PERF_CNT_EN
- Defined:
  - perf_stall_cnt increments on each cycle where priority 3 is the active case.
  - perf_flush_cnt increments on each cycle where priority 2 is the active case.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
1. Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs2=5 for one cycle, then ID_EX_MemRead=0 → cycle 1 has PC_Write=0, IF_ID_Stall=1, Control_Sig_Stall=1; cycle 2 has PC_Write=1; with macro, perf_stall_cnt=1.
2. x0 filter: ID_EX_MemRead=1, ID_EX_Rd=0, IF_ID_Rs1=0 → no stall, PC_Write=1.
3. Redirect vs load-use: PCSrc=1 and load_use true in the same cycle → IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, Control_Sig_Stall=0; with macro, perf_flush_cnt=1.
4. Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 → all holds =1 and PC_Write=0 for 4 cycles; FSM back in RUN on the 5th cycle; PCSrc=1 during the wait causes no flush.
5. Timeout: MEM_TIMEOUT=4, dmem_ready=0 for 6 cycles → mem_timeout=1 from the 4th wait cycle; stays 1 after dmem_ready; clears only when rst_n=0.
6. Async reset: assert rst_n=0 mid-MEM_WAIT between clock edges → outputs immediately take reset values; after release, dmem_req=0 gives PC_Write=1 with the FSM in RUN.
